sha256_round_seq: RTL and testbench

SHA256_ROUND_SEQ -- requirements
Module: sha256_round_seq

---
 rtl/sha256_pkg.sv | 16 +
 rtl/sha256_msg_sched.sv | 30 +++
 rtl/sha256_round_seq.sv | 85 ++++++++
 tb/tb_sha256_round_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared FSM state type, round count and message-schedule sigma functions
package sha256_pkg;

    localparam int SHA256_ROUNDS = 64;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: 16-word message-schedule window with same-cycle expansion
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [31:0] word_i,
    input  logic        adv_i,
    output logic [31:0] w_t_o
);

    logic [15:0][31:0] win_q, win_d;
    logic [31:0]       exp_w;

    assign exp_w = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];
    assign w_t_o = win_q[0];

    // loaded words and expanded words both enter at the top; entry 0 is always W_t
    always_comb begin
        win_d = load_i ? {word_i, win_q[15:1]} : adv_i ? {exp_w, win_q[15:1]} : win_q;
    end

    // window register, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) win_q <= '0;
        else        win_q <= win_d;
    end

endmodule

// File: rtl/sha256_round_seq.sv
// sha256_round_seq: loads one 16-word block and issues ROUNDS schedule words with round indices
module sha256_round_seq
    import sha256_pkg::*;
#(
    parameter int ROUNDS = SHA256_ROUNDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [31:0] blk_word_i,
    input  logic        blk_valid_i,
    output logic        blk_ready_o,
    input  logic        hold_i,
    output logic [5:0]  k_addr_o,
    output logic [31:0] w_t_o,
    output logic        rnd_valid_o,
    output logic [5:0]  rnd_idx_o,
    output logic        first_o,
    output logic        last_o,
    output logic        busy_o,
    output logic        done_o
);

    if (ROUNDS < 16 || ROUNDS > 64) begin : g_bad_rounds
        $error("ROUNDS must be in 16..64");
    end

    localparam logic [5:0] T_LAST = 6'(ROUNDS - 1);

    state_e      state_q, state_d;
    logic [3:0]  ld_cnt_q, ld_cnt_d;
    logic [5:0]  t_q, t_d;
    logic        blk_ready_q, busy_q, done_q;
    logic        accept, issue;

    assign accept      = blk_valid_i && state_q == LOAD;
    assign issue       = state_q == RUN && !hold_i;
    assign blk_ready_o = blk_ready_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign k_addr_o    = t_q;
    assign rnd_idx_o   = t_q;
    assign rnd_valid_o = issue;
    assign first_o     = issue && t_q == 6'd0;
    assign last_o      = issue && t_q == T_LAST;

    // next state and counters; t returns to 0 after the last round so it idles at 0
    always_comb begin
        state_d  = state_q == IDLE ? (start_i ? LOAD : IDLE)
                 : state_q == LOAD ? (accept && ld_cnt_q == 4'd15 ? RUN : LOAD)
                 : state_q == RUN  ? (issue && t_q == T_LAST ? DONE : RUN)
                 : IDLE;
        ld_cnt_d = accept ? ld_cnt_q + 4'd1 : ld_cnt_q;
        t_d      = issue ? (t_q == T_LAST ? 6'd0 : t_q + 6'd1) : t_q;
    end

    // FSM state, counters and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ld_cnt_q    <= '0;
            t_q         <= '0;
            blk_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_cnt_q    <= ld_cnt_d;
            t_q         <= t_d;
            blk_ready_q <= state_d == LOAD;
            busy_q      <= state_d == LOAD || state_d == RUN;
            done_q      <= state_d == DONE;
        end
    end

    sha256_msg_sched u_sched (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (accept),
        .word_i (blk_word_i),
        .adv_i  (issue),
        .w_t_o  (w_t_o)
    );

endmodule

// File: tb/tb_sha256_round_seq.sv
// tb_sha256_round_seq: directed checks of block load, round issue, hold, reset and ROUNDS=16
module tb_sha256_round_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, start16 = 1'b0;
    logic [31:0] blk_word = '0;
    logic        blk_valid = 1'b0;
    logic        hold = 1'b0;
    logic        hold16 = 1'b0;

    logic        blk_ready, rnd_valid, first, last, busy, done;
    logic [5:0]  k_addr, rnd_idx;
    logic [31:0] w_t;
    logic        blk_ready16, rnd_valid16, first16, last16, busy16, done16;
    logic [5:0]  k_addr16, rnd_idx16;
    logic [31:0] w_t16;

    int checks = 0, errors = 0, ngap = 0;

    logic [31:0] abc  [16];
    logic [31:0] wexp [64];
    logic [31:0] obs  [64];

    typedef struct {
        int          t;
        logic [31:0] w;
    } vec_t;
    vec_t tbl [18];

    always #5 clk = ~clk;

    sha256_round_seq dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .blk_word_i(blk_word), .blk_valid_i(blk_valid),
        .blk_ready_o(blk_ready), .hold_i(hold), .k_addr_o(k_addr), .w_t_o(w_t), .rnd_valid_o(rnd_valid),
        .rnd_idx_o(rnd_idx), .first_o(first), .last_o(last), .busy_o(busy), .done_o(done)
    );

    sha256_round_seq #(.ROUNDS(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start_i(start16), .blk_word_i(blk_word), .blk_valid_i(blk_valid),
        .blk_ready_o(blk_ready16), .hold_i(hold16), .k_addr_o(k_addr16), .w_t_o(w_t16), .rnd_valid_o(rnd_valid16),
        .rnd_idx_o(rnd_idx16), .first_o(first16), .last_o(last16), .busy_o(busy16), .done_o(done16)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    task automatic build_model();
        for (int i = 0; i < 64; i++)
            wexp[i] = i < 16 ? abc[i]
                    : (ror(wexp[i-2], 17) ^ ror(wexp[i-2], 19) ^ (wexp[i-2] >> 10)) + wexp[i-7]
                      + (ror(wexp[i-15], 7) ^ ror(wexp[i-15], 18) ^ (wexp[i-15] >> 3)) + wexp[i-16];
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_ready"}, blk_ready, 0);
        chk({tag, "_rv"}, rnd_valid, 0);
        chk({tag, "_kaddr"}, k_addr, 0);
        chk({tag, "_idx"}, rnd_idx, 0);
        chk({tag, "_wt"}, w_t, 0);
        chk({tag, "_fl"}, {first, last, busy, done}, 0);
    endtask

    task automatic run_block(input bit gaps, input bit holds, input bit spur, input int rst_at,
                             input bit chk16, output int done_cyc);
        int acc, t, ndone, d16_cyc, l16_cyc, n_l16;
        bit held, fin;
        acc = 0; t = 0; ndone = 0; held = 0; fin = 0;
        done_cyc = -1; d16_cyc = -1; l16_cyc = -1; n_l16 = 0;
        @(negedge clk);
        start = 1'b1; start16 = chk16;
        #1;
        chk("start_cyc_ready", blk_ready, 0);
        for (int cyc = 2; cyc < 400 && !fin; cyc++) begin
            @(negedge clk);
            start = 1'b0; start16 = 1'b0; blk_valid = 1'b0; blk_word = 32'hdeadbeef; hold = 1'b0;
            if (acc < 16) begin
                blk_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (blk_valid) blk_word = abc[acc];
                else ngap++;
                #1;
                chk("load_ready", blk_ready, 1);
                chk("load_busy", busy, 1);
                chk("load_rv", rnd_valid, 0);
                if (blk_valid) acc++;
            end else if (t < 64) begin
                hold  = holds && !held && (t == 0 || t == 17 || t == 63);
                start = spur && t == 20;
                if (rst_at == t) begin
                    rst_n = 1'b0;
                    #1;
                    all_zero("rst_mid");
                    repeat (2) begin
                        @(negedge clk);
                        chk("rst_no_done", done, 0);
                    end
                    rst_n = 1'b1;
                    fin = 1;
                end else begin
                    #1;
                    chk("rnd_valid", rnd_valid, !hold);
                    chk("rnd_idx", rnd_idx, t);
                    chk("k_addr", k_addr, t);
                    chk("w_t", w_t, wexp[t]);
                    chk("first", first, !hold && t == 0);
                    chk("last", last, !hold && t == 63);
                    chk("run_ready", blk_ready, 0);
                    chk("run_busy", busy, 1);
                    if (!hold) obs[t] = w_t;
                    held = hold;
                    if (!hold) t++;
                end
            end else begin
                start = spur;
                #1;
                chk("done_pulse", done, 1);
                chk("done_busy", busy, 0);
                chk("done_rv", rnd_valid, 0);
                done_cyc = cyc;
                fin = 1;
            end
            if (done) ndone++;
            if (chk16 && done16 && d16_cyc < 0) d16_cyc = cyc;
            if (chk16 && last16) begin
                l16_cyc = cyc;
                n_l16++;
            end
        end
        if (!fin) chk("timeout", 0, 1);
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            chk("idle_ready", blk_ready, 0);
            chk("idle_busy", busy, 0);
            chk("idle_kaddr", k_addr, 0);
            if (done) ndone++;
        end
        chk("done_count", ndone, rst_at < 0 ? 1 : 0);
        if (chk16) begin
            chk("r16_done_cyc", d16_cyc, 34);
            chk("r16_last_cyc", l16_cyc, 33);
            chk("r16_last_cnt", n_l16, 1);
        end
    endtask

    initial begin
        int dc;
        for (int i = 0; i < 16; i++) abc[i] = 32'h0;
        abc[0]  = 32'h61626380;
        abc[15] = 32'h00000018;
        for (int i = 0; i < 16; i++) tbl[i] = '{i, abc[i]};
        tbl[16] = '{16, 32'h61626380};
        tbl[17] = '{17, 32'h000F0000};
        build_model();

        #2;
        all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        all_zero("post_reset");

        run_block(0, 0, 0, -1, 1, dc);
        chk("abc_done_cyc", dc, 82);
        for (int i = 0; i < 18; i++) chk($sformatf("abc_W%0d", tbl[i].t), obs[tbl[i].t], tbl[i].w);

        run_block(0, 1, 0, -1, 0, dc);
        chk("hold_done_cyc", dc, 85);

        ngap = 0;
        run_block(1, 0, 0, -1, 0, dc);
        chk("gap_done_cyc", dc, 82 + ngap);

        run_block(0, 0, 1, -1, 0, dc);
        chk("spur_done_cyc", dc, 82);

        run_block(0, 0, 0, 30, 0, dc);
        run_block(0, 0, 0, -1, 0, dc);
        chk("post_rst_done_cyc", dc, 82);
        chk("post_rst_W17", obs[17], 32'h000F0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
